// File: rtl/nn_config_pkg.sv
// Shared network configuration: layer sizes, p2s FSM states and width helper.
// Layer sizes feed num_elem of each layer_p2s instance in dnn.
package nn_config_pkg;

  localparam int num_neuron_layer1 = 30;
  localparam int num_neuron_layer2 = 20;
  localparam int num_neuron_layer3 = 10;
  localparam int num_neuron_layer4 = 10;

  typedef enum logic [0:0] {
    P2S_IDLE = 1'b0,
    P2S_SEND = 1'b1
  } p2s_state_e;

  // Index/counter width that stays at least one bit for tiny n.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p2s_frame_buf.sv
// Frame storage for layer_p2s: num_buf flat frame registers with write/read pointers.
// Latency: capture visible to the reader one edge later; word mux is combinational.
// Backpressure: free count exposes buffer availability; the reader frees a buffer on rel.
module p2s_frame_buf
  import nn_config_pkg::*;
#(
  parameter int num_elem   = 30,
  parameter int data_width = 16,
  parameter int num_buf    = 2,
  parameter int lsb_first  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [num_elem*data_width-1:0]        wr_data,
  input  logic                                  rel,
  input  logic [idx_width(num_elem)-1:0]        rd_idx,
  output logic [data_width-1:0]                 rd_word,
  output logic                                  rd_full,
  output logic                                  nxt_avail,
  output logic [idx_width(num_buf+1)-1:0]       free_nxt
);

  localparam int iw = idx_width(num_elem);
  localparam int pw = idx_width(num_buf);
  localparam int cw = idx_width(num_buf + 1);

  logic [num_elem*data_width-1:0] mem [num_buf];
  logic [num_buf-1:0]             full;
  logic [pw-1:0]                  wr_ptr;
  logic [pw-1:0]                  rd_ptr;
  logic [pw-1:0]                  nxt_ptr;
  logic [cw-1:0]                  free_cnt;
  logic [iw-1:0]                  sel;

  function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
    return (int'(p) == num_buf - 1) ? '0 : p + 1'b1;
  endfunction

  assign nxt_ptr = ptr_inc(rd_ptr);
  assign rd_full = full[rd_ptr];
  // A frame landing in the next buffer on the same edge still counts, so no bubble.
  assign nxt_avail = (num_buf > 1) && (full[nxt_ptr] || (wr_en && (wr_ptr == nxt_ptr)));
  assign free_nxt  = free_cnt - cw'(wr_en) + cw'(rel);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      free_cnt <= cw'(num_buf);
    end else begin
      free_cnt <= free_nxt;
      if (wr_en) begin
        wr_ptr       <= ptr_inc(wr_ptr);
        full[wr_ptr] <= 1'b1;
      end
      if (rel) begin
        rd_ptr       <= nxt_ptr;
        full[rd_ptr] <= 1'b0;
      end
    end
  end

  // Frame data needs no reset: the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Indexed select keeps the stored frame intact while streaming.
  assign sel     = (lsb_first != 0) ? rd_idx : (iw'(num_elem - 1) - rd_idx);
  assign rd_word = mem[rd_ptr][int'(sel)*data_width +: data_width];

endmodule

// File: rtl/layer_p2s.sv
// Parallel-to-serial bridge between NN layers; optional LAYER_P2S_INDEX_EN adds o_index/o_frame_cnt.
// Latency: frame captured at edge N shows word 0 after edge N+1; frames stream back-to-back.
// Backpressure: words hold while o_ready is low; i_ready is registered and drops when no buffer is free.
module layer_p2s
  import nn_config_pkg::*;
#(
  parameter int num_elem   = 30,
  parameter int data_width = 16,
  parameter int num_buf    = 2,
  parameter int lsb_first  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [num_elem*data_width-1:0]  i_data,
  input  logic                            i_valid,
  output logic                            i_ready,
  output logic [data_width-1:0]           o_data,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic                            o_last,
  output logic                            o_overflow
`ifdef LAYER_P2S_INDEX_EN
  ,
  output logic [idx_width(num_elem)-1:0]  o_index,
  output logic [15:0]                     o_frame_cnt
`endif
);

  localparam int iw = idx_width(num_elem);
  localparam int cw = idx_width(num_buf + 1);

  localparam logic [0:0] IDLE = P2S_IDLE;
  localparam logic [0:0] SEND = P2S_SEND;

  logic [0:0]            state;
  logic [iw-1:0]         k;
  logic                  last_k;
  logic                  accept;
  logic                  wr_en;
  logic                  rel;
  logic                  rd_full;
  logic                  nxt_avail;
  logic [cw-1:0]         free_nxt;
  logic [data_width-1:0] rd_word;

  assign wr_en  = i_valid && i_ready;
  assign last_k = (k == iw'(num_elem - 1));
  assign accept = o_valid && o_ready;
  assign rel    = accept && last_k;

  assign o_data = o_valid ? rd_word : '0;
  assign o_last = o_valid && last_k;

  p2s_frame_buf #(
    .num_elem   (num_elem),
    .data_width (data_width),
    .num_buf    (num_buf),
    .lsb_first  (lsb_first)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (i_data),
    .rel       (rel),
    .rd_idx    (k),
    .rd_word   (rd_word),
    .rd_full   (rd_full),
    .nxt_avail (nxt_avail),
    .free_nxt  (free_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      k          <= '0;
      o_valid    <= 1'b0;
      i_ready    <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      i_ready <= (free_nxt != '0);
      if (i_valid && !i_ready) o_overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (rd_full) begin
            state   <= SEND;
            o_valid <= 1'b1;
            k       <= '0;
          end
        end
        default: begin
          if (accept) begin
            if (!last_k) begin
              k <= k + 1'b1;
            end else begin
              k <= '0;
              if (!nxt_avail) begin
                state   <= IDLE;
                o_valid <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

`ifdef LAYER_P2S_INDEX_EN
  assign o_index = k;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_frame_cnt <= '0;
    else if (rel) o_frame_cnt <= o_frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_layer_p2s.sv
// Directed bench for layer_p2s: three instances (2 buffers lsb-first, 1 buffer, msb-first).
module tb_layer_p2s;

  localparam int NE = 4;
  localparam int DW = 16;

  localparam logic [NE*DW-1:0] FRAME_A = 64'h0004_0003_0002_0001;
  localparam logic [NE*DW-1:0] FRAME_B = 64'h0008_0007_0006_0005;
  localparam logic [NE*DW-1:0] FRAME_C = 64'h000d_000c_000b_000a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NE*DW-1:0] i_data;
  logic             iv   [3];
  logic             ordy [3];
  logic             irdy [3];
  logic             ov   [3];
  logic             ol   [3];
  logic             oovf [3];
  logic [DW-1:0]    od   [3];
`ifdef LAYER_P2S_INDEX_EN
  logic [1:0]       oidx [3];
  logic [15:0]      ofc  [3];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  layer_p2s #(.num_elem(NE), .data_width(DW), .num_buf(2), .lsb_first(1)) dut0 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(iv[0]), .i_ready(irdy[0]),
    .o_data(od[0]), .o_valid(ov[0]), .o_ready(ordy[0]), .o_last(ol[0]), .o_overflow(oovf[0])
`ifdef LAYER_P2S_INDEX_EN
    , .o_index(oidx[0]), .o_frame_cnt(ofc[0])
`endif
  );

  layer_p2s #(.num_elem(NE), .data_width(DW), .num_buf(1), .lsb_first(1)) dut1 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(iv[1]), .i_ready(irdy[1]),
    .o_data(od[1]), .o_valid(ov[1]), .o_ready(ordy[1]), .o_last(ol[1]), .o_overflow(oovf[1])
`ifdef LAYER_P2S_INDEX_EN
    , .o_index(oidx[1]), .o_frame_cnt(ofc[1])
`endif
  );

  layer_p2s #(.num_elem(NE), .data_width(DW), .num_buf(2), .lsb_first(0)) dut2 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(iv[2]), .i_ready(irdy[2]),
    .o_data(od[2]), .o_valid(ov[2]), .o_ready(ordy[2]), .o_last(ol[2]), .o_overflow(oovf[2])
`ifdef LAYER_P2S_INDEX_EN
    , .o_index(oidx[2]), .o_frame_cnt(ofc[2])
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input int d, input int dat, input int idx, input string tag);
    check_eq({tag, ".vld"},  32'(ov[d]), 32'd1);
    check_eq({tag, ".dat"},  32'(od[d]), 32'(dat));
    check_eq({tag, ".last"}, 32'(ol[d]), (idx == NE - 1) ? 32'd1 : 32'd0);
`ifdef LAYER_P2S_INDEX_EN
    check_eq({tag, ".idx"},  32'(oidx[d]), 32'(idx));
`endif
  endtask

  task automatic capture(input int d, input logic [NE*DW-1:0] data);
    i_data = data;
    iv[d]  = 1'b1;
    step;
    iv[d]  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    i_data = '0;
    #1 rst = 1'b0;
    step;
    step;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst%0d.irdy", d), 32'(irdy[d]), 32'd1);
      check_eq($sformatf("rst%0d.vld", d),  32'(ov[d]),   32'd0);
      check_eq($sformatf("rst%0d.dat", d),  32'(od[d]),   32'd0);
      check_eq($sformatf("rst%0d.last", d), 32'(ol[d]),   32'd0);
      check_eq($sformatf("rst%0d.ovf", d),  32'(oovf[d]), 32'd0);
    end
    rst = 1'b1;
    step;

    // Single frame, free-running sink
    capture(0, FRAME_A);
    check_eq("t1.latency", 32'(ov[0]), 32'd0);
    check_eq("t1.irdy", 32'(irdy[0]), 32'd1);
    step;
    for (int w = 0; w < NE; w++) begin
      expect_word(0, w + 1, w, $sformatf("t1.w%0d", w));
      step;
    end
    check_eq("t1.end", 32'(ov[0]), 32'd0);

    // Backpressure on word 2
    capture(0, FRAME_A);
    step;
    expect_word(0, 1, 0, "t2.w0");
    step;
    ordy[0] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      expect_word(0, 2, 1, $sformatf("t2.stall%0d", s));
      step;
    end
    ordy[0] = 1'b1;
    expect_word(0, 2, 1, "t2.w1");
    step;
    expect_word(0, 3, 2, "t2.w2");
    step;
    expect_word(0, 4, 3, "t2.w3");
    step;
    check_eq("t2.end", 32'(ov[0]), 32'd0);

    // Back-to-back frames with two buffers
    capture(0, FRAME_A);
    i_data = FRAME_B;
    step;
    expect_word(0, 1, 0, "t3.w0");
    iv[0] = 1'b1;
    step;
    iv[0] = 1'b0;
    expect_word(0, 2, 1, "t3.w1");
    check_eq("t3.irdy_full", 32'(irdy[0]), 32'd0);
    step;
    for (int w = 2; w < 2 * NE; w++) begin
      expect_word(0, w + 1, w % NE, $sformatf("t3.w%0d", w));
      step;
    end
    check_eq("t3.end", 32'(ov[0]), 32'd0);
    check_eq("t3.irdy_end", 32'(irdy[0]), 32'd1);

    // Overflow with a single buffer
    capture(1, FRAME_A);
    check_eq("t4.irdy_busy", 32'(irdy[1]), 32'd0);
    step;
    expect_word(1, 1, 0, "t4.w0");
    iv[1]  = 1'b1;
    i_data = FRAME_B;
    step;
    iv[1]  = 1'b0;
    check_eq("t4.ovf", 32'(oovf[1]), 32'd1);
    expect_word(1, 2, 1, "t4.w1");
    step;
    expect_word(1, 3, 2, "t4.w2");
    step;
    expect_word(1, 4, 3, "t4.w3");
    step;
    check_eq("t4.end", 32'(ov[1]), 32'd0);
    check_eq("t4.irdy_end", 32'(irdy[1]), 32'd1);
    step;
    step;
    check_eq("t4.no_extra", 32'(ov[1]), 32'd0);
    check_eq("t4.ovf_sticky", 32'(oovf[1]), 32'd1);

    // Highest word first
    capture(2, FRAME_A);
    step;
    for (int w = 0; w < NE; w++) begin
      expect_word(2, NE - w, w, $sformatf("t5.w%0d", w));
      step;
    end
    check_eq("t5.end", 32'(ov[2]), 32'd0);

    // Reset in the middle of a frame
    capture(0, FRAME_A);
    step;
    expect_word(0, 1, 0, "t6.w0");
    step;
    expect_word(0, 2, 1, "t6.w1");
    rst = 1'b0;
    #1;
    check_eq("t6.rst_vld",  32'(ov[0]),   32'd0);
    check_eq("t6.rst_dat",  32'(od[0]),   32'd0);
    check_eq("t6.rst_last", 32'(ol[0]),   32'd0);
    check_eq("t6.rst_irdy", 32'(irdy[0]), 32'd1);
    check_eq("t6.rst_ovf1", 32'(oovf[1]), 32'd0);
`ifdef LAYER_P2S_INDEX_EN
    check_eq("t6.rst_idx", 32'(oidx[0]), 32'd0);
    check_eq("t6.rst_fcnt", 32'(ofc[0]), 32'd0);
`endif
    step;
    rst = 1'b1;
    step;
    check_eq("t6.idle", 32'(ov[0]), 32'd0);
    capture(0, FRAME_C);
    step;
    for (int w = 0; w < NE; w++) begin
      expect_word(0, 16'h000a + w, w, $sformatf("t6.w%0d", w));
      step;
    end
    check_eq("t6.end", 32'(ov[0]), 32'd0);
`ifdef LAYER_P2S_INDEX_EN
    check_eq("t6.fcnt", 32'(ofc[0]), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
